// File: rtl/div_issue_queue.sv
// Reservation station for the iterative divider: captures CDB operands and issues one ready op per 6-cycle slot.
// Define DIV_IQ_AGE_SELECT_EN for oldest-first selection (age matrix); default is lowest-index selection.
module div_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_en,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic [TAG_W-1:0] dispatch_op1_tag,
  input  logic [31:0]      dispatch_op1,
  input  logic [TAG_W-1:0] dispatch_op2_tag,
  input  logic [31:0]      dispatch_op2,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             div_busy,
  output logic             queue_en,
  output logic             tag_in_valid,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  output logic [2:0]       funct3,
  output logic [TAG_W-1:0] tag_in,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LOCK_W  = 3;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(5);

  logic [DEPTH-1:0]            e_valid_q,   e_valid_d;
  logic [DEPTH-1:0][2:0]       e_funct3_q,  e_funct3_d;
  logic [DEPTH-1:0][TAG_W-1:0] e_tag_q,     e_tag_d;
  logic [DEPTH-1:0][31:0]      e_op1_q,     e_op1_d;
  logic [DEPTH-1:0][TAG_W-1:0] e_op1_tag_q, e_op1_tag_d;
  logic [DEPTH-1:0][31:0]      e_op2_q,     e_op2_d;
  logic [DEPTH-1:0][TAG_W-1:0] e_op2_tag_q, e_op2_tag_d;

  logic [LOCK_W-1:0] lockout_q, lockout_d;
  logic              queue_en_q, queue_en_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [TAG_W-1:0]  tag_in_q, tag_in_d;

`ifdef DIV_IQ_AGE_SELECT_EN
  // age_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic                        older;
`endif

  logic [DEPTH-1:0] elig;
  logic             sel_found, free_found, issue, cdb_hit;
  logic [IDX_W-1:0] sel_idx, free_idx;

  assign full         = &e_valid_q;
  assign empty        = ~|e_valid_q;
  assign queue_en     = queue_en_q;
  assign tag_in_valid = queue_en_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign funct3       = funct3_q;
  assign tag_in       = tag_in_q;

  // Selection, CDB capture, issue and dispatch
  always_comb begin
    e_valid_d   = e_valid_q;
    e_funct3_d  = e_funct3_q;
    e_tag_d     = e_tag_q;
    e_op1_d     = e_op1_q;
    e_op1_tag_d = e_op1_tag_q;
    e_op2_d     = e_op2_q;
    e_op2_tag_d = e_op2_tag_q;
    lockout_d   = (lockout_q != '0) ? lockout_q - LOCK_W'(1) : '0;
    queue_en_d  = 1'b0;
    op1_d       = op1_q;
    op2_d       = op2_q;
    funct3_d    = funct3_q;
    tag_in_d    = tag_in_q;
    sel_found   = 1'b0;
    sel_idx     = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    cdb_hit     = cdb_valid && (cdb_tag != '0);
`ifdef DIV_IQ_AGE_SELECT_EN
    age_d       = age_q;
    older       = 1'b0;
`endif

    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = e_valid_q[i] && (e_op1_tag_q[i] == '0) && (e_op2_tag_q[i] == '0);
    end

`ifdef DIV_IQ_AGE_SELECT_EN
    for (int i = 0; i < DEPTH; i++) begin
      older = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && elig[j] && !age_q[i][j]) older = 1'b0;
      end
      if (older && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif

    for (int i = 0; i < DEPTH; i++) begin
      if (!e_valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid_q[i] && cdb_hit && (e_op1_tag_q[i] == cdb_tag)) begin
        e_op1_d[i]     = cdb_data;
        e_op1_tag_d[i] = '0;
      end
      if (e_valid_q[i] && cdb_hit && (e_op2_tag_q[i] == cdb_tag)) begin
        e_op2_d[i]     = cdb_data;
        e_op2_tag_d[i] = '0;
      end
    end

    // Lockout covers the divider's final cycle where busy is low but queue_en is ignored
    issue = sel_found && !div_busy && (lockout_q == '0);
    if (issue) begin
      e_valid_d[sel_idx] = 1'b0;
      queue_en_d         = 1'b1;
      op1_d              = e_op1_q[sel_idx];
      op2_d              = e_op2_q[sel_idx];
      funct3_d           = e_funct3_q[sel_idx];
      tag_in_d           = e_tag_q[sel_idx];
      lockout_d          = LOCK_LOAD;
`ifdef DIV_IQ_AGE_SELECT_EN
      age_d[sel_idx]     = '0;
`endif
    end

    // full is judged on pre-edge occupancy, so free_found implies !full
    if (dispatch_en && !full && free_found) begin
      e_valid_d[free_idx]   = 1'b1;
      e_funct3_d[free_idx]  = dispatch_funct3;
      e_tag_d[free_idx]     = dispatch_tag;
      e_op1_d[free_idx]     = dispatch_op1;
      e_op1_tag_d[free_idx] = dispatch_op1_tag;
      e_op2_d[free_idx]     = dispatch_op2;
      e_op2_tag_d[free_idx] = dispatch_op2_tag;
      if (cdb_hit && (dispatch_op1_tag == cdb_tag)) begin
        e_op1_d[free_idx]     = cdb_data;
        e_op1_tag_d[free_idx] = '0;
      end
      if (cdb_hit && (dispatch_op2_tag == cdb_tag)) begin
        e_op2_d[free_idx]     = cdb_data;
        e_op2_tag_d[free_idx] = '0;
      end
`ifdef DIV_IQ_AGE_SELECT_EN
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) != free_idx) age_d[j][free_idx] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q   <= '0;
      e_funct3_q  <= '0;
      e_tag_q     <= '0;
      e_op1_q     <= '0;
      e_op1_tag_q <= '0;
      e_op2_q     <= '0;
      e_op2_tag_q <= '0;
      lockout_q   <= '0;
      queue_en_q  <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      funct3_q    <= '0;
      tag_in_q    <= '0;
`ifdef DIV_IQ_AGE_SELECT_EN
      age_q       <= '0;
`endif
    end else begin
      e_valid_q   <= e_valid_d;
      e_funct3_q  <= e_funct3_d;
      e_tag_q     <= e_tag_d;
      e_op1_q     <= e_op1_d;
      e_op1_tag_q <= e_op1_tag_d;
      e_op2_q     <= e_op2_d;
      e_op2_tag_q <= e_op2_tag_d;
      lockout_q   <= lockout_d;
      queue_en_q  <= queue_en_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      funct3_q    <= funct3_d;
      tag_in_q    <= tag_in_d;
`ifdef DIV_IQ_AGE_SELECT_EN
      age_q       <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue: issue latency, 6-cycle spacing, CDB wakeup/bypass, full drop, reset.
module tb_div_issue_queue;

  localparam int unsigned TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch_en;
  logic [2:0]       dispatch_funct3;
  logic [TAG_W-1:0] dispatch_tag, dispatch_op1_tag, dispatch_op2_tag;
  logic [31:0]      dispatch_op1, dispatch_op2;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             div_busy;
  logic             queue_en, tag_in_valid, full, empty;
  logic [31:0]      op1, op2;
  logic [2:0]       funct3;
  logic [TAG_W-1:0] tag_in;

  int n_assert = 0;
  int n_fail   = 0;

  div_issue_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .dispatch_en(dispatch_en), .dispatch_funct3(dispatch_funct3), .dispatch_tag(dispatch_tag),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op1(dispatch_op1),
    .dispatch_op2_tag(dispatch_op2_tag), .dispatch_op2(dispatch_op2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .div_busy(div_busy),
    .queue_en(queue_en), .tag_in_valid(tag_in_valid), .op1(op1), .op2(op2),
    .funct3(funct3), .tag_in(tag_in), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [5:0] t, input logic [2:0] f,
                      input logic [5:0] q1, input logic [31:0] v1,
                      input logic [5:0] q2, input logic [31:0] v2);
    dispatch_en      = 1'b1;
    dispatch_tag     = t;
    dispatch_funct3  = f;
    dispatch_op1_tag = q1;
    dispatch_op1     = v1;
    dispatch_op2_tag = q2;
    dispatch_op2     = v2;
  endtask

  initial begin
    rst = 1'b1; dispatch_en = 1'b0; dispatch_funct3 = '0; dispatch_tag = '0;
    dispatch_op1_tag = '0; dispatch_op1 = '0; dispatch_op2_tag = '0; dispatch_op2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; div_busy = 1'b0;
    idle(2);
    chk("rst_queue_en", 32'(queue_en), 32'd0);
    chk("rst_tag_valid", 32'(tag_in_valid), 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_tag_in", 32'(tag_in), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    tick();

    // Single ready op: issue on the edge after dispatch
    disp(6'd5, 3'd4, 6'd0, 32'd100, 6'd0, 32'd7);
    tick();
    dispatch_en = 1'b0;
    chk("t1_not_yet", 32'(queue_en), 32'd0);
    chk("t1_empty_low", 32'(empty), 32'd0);
    tick();
    chk("t1_queue_en", 32'(queue_en), 32'd1);
    chk("t1_tag_valid", 32'(tag_in_valid), 32'd1);
    chk("t1_op1", op1, 32'd100);
    chk("t1_op2", op2, 32'd7);
    chk("t1_funct3", 32'(funct3), 32'd4);
    chk("t1_tag_in", 32'(tag_in), 32'd5);
    chk("t1_empty", 32'(empty), 32'd1);
    tick();
    chk("t1_pulse", 32'(queue_en), 32'd0);
    chk("t1_hold_op1", op1, 32'd100);
    idle(6);

    // Two back-to-back ready ops: issues 6 edges apart, none while busy
    disp(6'd10, 3'd5, 6'd0, 32'd20, 6'd0, 32'd4);
    tick();
    disp(6'd11, 3'd7, 6'd0, 32'd21, 6'd0, 32'd5);
    tick();
    dispatch_en = 1'b0;
    chk("t2_a_issue", 32'(queue_en), 32'd1);
    chk("t2_a_tag", 32'(tag_in), 32'd10);
    div_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2_gap", 32'(queue_en), 32'd0);
    end
    div_busy = 1'b0;
    tick();
    chk("t2_b_issue", 32'(queue_en), 32'd1);
    chk("t2_b_tag", 32'(tag_in), 32'd11);
    chk("t2_b_op2", op2, 32'd5);
    chk("t2_b_funct3", 32'(funct3), 32'd7);
    tick();
    chk("t2_pulse", 32'(queue_en), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);
    idle(6);

    // CDB wakeup: eligible one edge after capture
    disp(6'd7, 3'd6, 6'd0, 32'd50, 6'd9, 32'hDEAD);
    tick();
    dispatch_en = 1'b0;
    tick();
    chk("t3_wait1", 32'(queue_en), 32'd0);
    tick();
    chk("t3_wait2", 32'(queue_en), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd3;
    tick();
    cdb_valid = 1'b0;
    chk("t3_capture_edge", 32'(queue_en), 32'd0);
    tick();
    chk("t3_issue", 32'(queue_en), 32'd1);
    chk("t3_op2", op2, 32'd3);
    chk("t3_op1", op1, 32'd50);
    chk("t3_tag", 32'(tag_in), 32'd7);
    tick();
    idle(6);

    // div_busy holds back an eligible entry
    div_busy = 1'b1;
    disp(6'd13, 3'd4, 6'd0, 32'd8, 6'd0, 32'd2);
    tick();
    dispatch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_hold", 32'(queue_en), 32'd0);
    end
    div_busy = 1'b0;
    tick();
    chk("busy_release", 32'(queue_en), 32'd1);
    chk("busy_tag", 32'(tag_in), 32'd13);
    tick();
    idle(6);

    // Dispatch-cycle bypass from the CDB
    disp(6'd8, 3'd5, 6'd12, 32'h1111, 6'd0, 32'd2);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hFFFF_FFF0;
    tick();
    dispatch_en = 1'b0; cdb_valid = 1'b0;
    tick();
    chk("t4_issue", 32'(queue_en), 32'd1);
    chk("t4_op1", op1, 32'hFFFF_FFF0);
    chk("t4_tag", 32'(tag_in), 32'd8);
    tick();
    idle(6);

    // Fill with unresolved ops; fifth dispatch is dropped
    disp(6'd20, 3'd4, 6'd30, 32'd0, 6'd0, 32'h20);
    tick();
    disp(6'd21, 3'd5, 6'd0, 32'h21, 6'd31, 32'd0);
    tick();
    disp(6'd22, 3'd6, 6'd30, 32'd0, 6'd0, 32'h22);
    tick();
    disp(6'd23, 3'd7, 6'd30, 32'd0, 6'd31, 32'd0);
    tick();
    chk("t5_full", 32'(full), 32'd1);
    disp(6'd24, 3'd4, 6'd0, 32'd1, 6'd0, 32'd1);
    tick();
    dispatch_en = 1'b0;
    chk("t5_still_full", 32'(full), 32'd1);
    tick();
    chk("t5_drop_no_issue", 32'(queue_en), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd30; cdb_data = 32'h30;
    tick();
    cdb_valid = 1'b0;
    chk("t5_capture_edge", 32'(queue_en), 32'd0);
    tick();
    chk("t5_first_issue", 32'(queue_en), 32'd1);
    chk("t5_first_tag", 32'(tag_in), 32'd20);
    chk("t5_first_op1", op1, 32'h30);
    chk("t5_not_full", 32'(full), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_gap", 32'(queue_en), 32'd0);
    end
    // Dispatch on the same edge as the second issue
    disp(6'd25, 3'd4, 6'd40, 32'd0, 6'd0, 32'd1);
    tick();
    dispatch_en = 1'b0;
    chk("t5_second_issue", 32'(queue_en), 32'd1);
    chk("t5_second_tag", 32'(tag_in), 32'd22);
    chk("t5_second_op1", op1, 32'h30);
    chk("t5_second_op2", op2, 32'h22);
    chk("t5_three_valid", 32'({full, empty}), 32'd0);

    // Asynchronous reset mid-lockout with three valid entries
    #2;
    rst = 1'b1;
    #1;
    chk("rst2_queue_en", 32'(queue_en), 32'd0);
    chk("rst2_tag_in", 32'(tag_in), 32'd0);
    chk("rst2_op1", op1, 32'd0);
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_full", 32'(full), 32'd0);
    tick();
    rst = 1'b0;
    disp(6'd26, 3'd5, 6'd0, 32'd9, 6'd0, 32'd3);
    tick();
    dispatch_en = 1'b0;
    tick();
    chk("rst2_new_issue", 32'(queue_en), 32'd1);
    chk("rst2_new_tag", 32'(tag_in), 32'd26);
    chk("rst2_new_op1", op1, 32'd9);
    // Old entries must not resurrect on their tags
    cdb_valid = 1'b1; cdb_tag = 6'd31; cdb_data = 32'h31;
    tick();
    cdb_tag = 6'd40;
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rst2_no_stale", 32'(queue_en), 32'd0);
    end
    chk("end_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Reservation station that feeds the iterative divide/remainder unit in the Tomasulo execution stage. It holds up to DEPTH dispatched DIV/DIVU/REM/REMU operations and captures pending source operands from the common data bus (CDB). It issues exactly one ready entry at a time to the divider through the divider's queue_en/op1/op2/funct3/tag_in port. It enforces the divider's 6-cycle occupancy, because the divider ignores queue_en in its final (result) cycle even though busy is low there.

## Interface
Parameters:
- DEPTH, 4: number of entries (2..8).
- TAG_W, 6: ROB tag width. Tag 0 is reserved and means "operand ready / no tag".

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- dispatch_en  in  1  write a new entry this cycle. Ignored when full=1.
- dispatch_funct3  in  3  divide variant; forwarded unchanged.
- dispatch_tag  in  TAG_W  destination tag of the operation.
- dispatch_op1_tag  in  TAG_W  producer tag of op1; 0 means dispatch_op1 is valid.
- dispatch_op1  in  32  op1 value, used when dispatch_op1_tag==0.
- dispatch_op2_tag  in  TAG_W  producer tag of op2; 0 means ready.
- dispatch_op2  in  32  op2 value.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- div_busy  in  1  divider busy flag.
- queue_en  out  1  one-cycle issue pulse to the divider.
- tag_in_valid  out  1  always equal to queue_en.
- op1  out  32  issued operand 1.
- op2  out  32  issued operand 2.
- funct3  out  3  issued funct3.
- tag_in  out  TAG_W  issued destination tag.
- full  out  1  all DEPTH entries valid.
- empty  out  1  no entry valid.

## Operation
Entry state:
- valid, funct3, tag.
- For each operand: value and pending tag qtag. The operand is ready when qtag==0.

Dispatch:
- When dispatch_en=1 and full=0, write the lowest-index invalid entry at the clock edge.
- Dispatch-cycle bypass: if cdb_valid=1 and cdb_tag equals a nonzero dispatch_opN_tag, store cdb_data and set qtag=0.

CDB capture:
- Every cycle, every valid entry with qtag==cdb_tag≠0 while cdb_valid=1 loads cdb_data and clears qtag.
- Any number of entries and operands may capture in the same cycle.

Issue eligibility: an entry is eligible when it is valid and both operands are ready. An issue happens when all of the following hold:
- at least one entry is eligible;
- div_busy==0;
- lockout==0.

At an issue edge:
- queue_en and tag_in_valid are registered to 1 for exactly one cycle.
- op1, op2, funct3 and tag_in are registered from the selected entry.
- The selected entry's valid bit is cleared.
- lockout is loaded with 5. Otherwise lockout decrements each cycle down to 0.
- op1, op2, funct3 and tag_in hold their last value when queue_en=0.

An entry that becomes ready through CDB capture on edge N is eligible from edge N+1 onward; there is no same-edge wakeup-and-issue.

Simultaneous events:
- Dispatch and issue in the same cycle are both performed.
- full is evaluated on pre-edge occupancy, so a dispatch while full is dropped even if an issue frees an entry on the same edge.
- An entry issued on the same edge as a CDB match is unaffected; it is already ready.

Reset, asserted at any time:
- All entries invalid, lockout=0.
- queue_en=0, tag_in_valid=0, op1=0, op2=0, funct3=0, tag_in=0.
- full=0, empty=1.
- Any in-flight operation is discarded.

## Timing
- Minimum dispatch-to-queue_en latency with ready operands: dispatch edge N, queue_en high during the cycle after edge N+1.
- Issue spacing is at least 6 cycles. After an issue at edge E, the next issue is possible at edge E+6, which lands while the divider has returned to its idle state.
- queue_en is high for 1 cycle and never on two consecutive cycles.
- full and empty are combinational from the valid bits.

## Configuration
- DIV_IQ_AGE_SELECT_EN defined: selection is oldest-first among eligible entries.
  - Age is tracked by a DEPTH×DEPTH age matrix, updated on dispatch and on issue.
- DIV_IQ_AGE_SELECT_EN undefined: selection is the lowest-index eligible entry, and no age state is present.

## Test plan
- Reset release, then dispatch {op1_tag=0, op1=100, op2_tag=0, op2=7, funct3=4, tag=5}:
  - queue_en pulses 1 cycle with op1=100, op2=7, funct3=4, tag_in=5;
  - empty returns to 1.
- Dispatch 2 ready entries back-to-back: issues occur exactly 6 cycles apart; queue_en is never asserted while div_busy=1.
- Dispatch an entry with op2_tag=9; 3 cycles later drive cdb_valid=1, cdb_tag=9, cdb_data=3: the entry issues with op2=3 one edge later, not on the capture edge.
- Dispatch with op1_tag=12 while cdb_valid=1, cdb_tag=12, cdb_data=0xFFFF_FFF0: the entry is immediately ready and issues with op1=0xFFFF_FFF0.
- Fill DEPTH=4 entries with unresolved tags: full=1, and a fifth dispatch_en is dropped. A CDB on a shared tag wakes multiple entries, which then issue in selection order (oldest first with DIV_IQ_AGE_SELECT_EN).
- Assert rst for one cycle mid-lockout with 3 valid entries: queue_en=0, empty=1, full=0 immediately; after reset a new ready dispatch issues without waiting for the old lockout.
